// File: rtl/bus_mem_pkg.sv
// Shared types and limits for the bus-side memory controller.
// Holds the FSM state enum and the wait-state counter sizing.
package bus_mem_pkg;

    localparam int WS_CNT_W        = 4;
    localparam int MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/bus_mem_ctrl_ld_reg.sv
// Load-enabled register with asynchronous active-low clear.
// Ports: clk, rst_n, ld (load enable), d (next value), q (held value).
module ld_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bus_mem_ctrl.sv
// Bus-side memory controller: MAR/MDR plus single-access SRAM cycles.
// Ports: Clk, Reset_n, BUS, LD_MAR, LD_MDR, MEM_RD, MEM_WR in; MAR, MDR,
// mem_addr, mem_wdata, strobes (ce/oe/we, active low), R, busy out.
module bus_mem_ctrl
    import bus_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] BUS,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              MEM_RD,
    input  logic              MEM_WR,
    output logic [DATA_W-1:0] MAR,
    output logic [DATA_W-1:0] MDR,
    output logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              R,
    output logic              busy
);

    // Out-of-range settings saturate rather than wrap the 4-bit counter.
    localparam int WS_EFF = (WAIT_STATES > MAX_WAIT_STATES) ?
                            MAX_WAIT_STATES : WAIT_STATES;
    localparam logic [WS_CNT_W-1:0] WS_INIT = WS_CNT_W'(WS_EFF);

    mem_state_t          state;
    logic [WS_CNT_W-1:0] cnt;

    logic              idle;
    logic              rd_last;
    logic              mar_ld;
    logic              mdr_ld;
    logic [DATA_W-1:0] mdr_d;

    assign idle    = (state == IDLE);
    assign rd_last = (state == RD) && (cnt == '0);

    // Registers only load from the bus while idle, which freezes
    // address and write data for the whole access.
    assign mar_ld = idle && LD_MAR;
    assign mdr_ld = (idle && LD_MDR) || rd_last;

    // 2:1 source select for MDR: read data on the final read edge.
    assign mdr_d = rd_last ? mem_rdata : BUS;

    ld_reg #(.W(DATA_W)) u_mar (
        .clk   (Clk),
        .rst_n (Reset_n),
        .ld    (mar_ld),
        .d     (BUS),
        .q     (MAR)
    );

    ld_reg #(.W(DATA_W)) u_mdr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .ld    (mdr_ld),
        .d     (mdr_d),
        .q     (MDR)
    );

    assign mem_addr  = MAR;
    assign mem_wdata = MDR;

    // Strobes, R and busy are registered alongside the next state so
    // they track it exactly and clear asynchronously with reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mem_ce_n <= 1'b1;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            R        <= 1'b0;
            busy     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    R <= 1'b0;
                    if (MEM_RD) begin
                        state    <= RD;
                        cnt      <= WS_INIT;
                        mem_ce_n <= 1'b0;
                        mem_oe_n <= 1'b0;
                        busy     <= 1'b1;
                    end else if (MEM_WR) begin
                        state    <= WR;
                        cnt      <= WS_INIT;
                        mem_ce_n <= 1'b0;
                        mem_we_n <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RD, WR: begin
                    if (cnt == '0) begin
                        state    <= DONE;
                        mem_ce_n <= 1'b1;
                        mem_oe_n <= 1'b1;
                        mem_we_n <= 1'b1;
                        R        <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    R     <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mem_ce_n <= 1'b1;
                    mem_oe_n <= 1'b1;
                    mem_we_n <= 1'b1;
                    R        <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Self-checking bench for bus_mem_ctrl (WAIT_STATES=2 and =0 instances).
// Table-driven cycle vectors via a scoreboard queue plus corner sequences.
module tb_bus_mem_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] BUS = 16'h0;
    logic        LD_MAR = 1'b0;
    logic        LD_MDR = 1'b0;
    logic        MEM_RD = 1'b0;
    logic        MEM_WR = 1'b0;
    logic [15:0] mem_rdata = 16'h0;

    logic [15:0] mar_a, mdr_a, addr_a, wdata_a;
    logic        ce_a, oe_a, we_a, r_a, busy_a;
    logic [15:0] mar_b, mdr_b, addr_b, wdata_b;
    logic        ce_b, oe_b, we_b, r_b, busy_b;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    bus_mem_ctrl #(.WAIT_STATES(2), .DATA_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .BUS(BUS),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .MAR(mar_a), .MDR(mdr_a),
        .mem_addr(addr_a), .mem_rdata(mem_rdata), .mem_wdata(wdata_a),
        .mem_ce_n(ce_a), .mem_oe_n(oe_a), .mem_we_n(we_a),
        .R(r_a), .busy(busy_a)
    );

    bus_mem_ctrl #(.WAIT_STATES(0), .DATA_W(16)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .BUS(BUS),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .MAR(mar_b), .MDR(mdr_b),
        .mem_addr(addr_b), .mem_rdata(mem_rdata), .mem_wdata(wdata_b),
        .mem_ce_n(ce_b), .mem_oe_n(oe_b), .mem_we_n(we_b),
        .R(r_b), .busy(busy_b)
    );

    // {ce_n, oe_n, we_n, R, busy}
    typedef struct {
        logic        ld_mar;
        logic        ld_mdr;
        logic        rd;
        logic        wr;
        logic [15:0] bus;
        logic [15:0] rdata;
        logic [15:0] mar;
        logic [15:0] mdr;
        logic [4:0]  st;
    } vec_t;

    logic [68:0] expq[$];

    function automatic logic [68:0] obs_a();
        return {mar_a, mdr_a, addr_a, wdata_a, ce_a, oe_a, we_a, r_a, busy_a};
    endfunction

    function automatic logic [68:0] obs_b();
        return {mar_b, mdr_b, addr_b, wdata_b, ce_b, oe_b, we_b, r_b, busy_b};
    endfunction

    function automatic logic [68:0] mk(logic [15:0] mar, logic [15:0] mdr,
                                       logic [4:0] st);
        return {mar, mdr, mar, mdr, st};
    endfunction

    task automatic check(string name, logic [68:0] act, logic [68:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(logic lm, logic ld, logic rd, logic wr,
                         logic [15:0] b, logic [15:0] rdat);
        LD_MAR = lm;
        LD_MDR = ld;
        MEM_RD = rd;
        MEM_WR = wr;
        BUS = b;
        mem_rdata = rdat;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((busy_a || busy_b) && n < 40) begin
            step();
            n++;
        end
        check(name, 69'(busy_a || busy_b), 69'(0));
    endtask

    vec_t tbl[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wlow, rcnt, badaddr, n;
        logic gotr;

        // Reset held with everything asserted.
        drive(1, 1, 1, 1, 16'hFFFF, 16'hFFFF);
        Reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_a", obs_a(), mk(16'h0, 16'h0, 5'b11100));
            check("reset_b", obs_b(), mk(16'h0, 16'h0, 5'b11100));
        end
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        Reset_n = 1'b1;
        step();
        check("post_reset_idle", obs_a(), mk(16'h0, 16'h0, 5'b11100));

        // Loads, then a WAIT_STATES=2 read with LD_MDR pulsed mid-read.
        tbl[0] = '{1, 0, 0, 0, 16'h3000, 16'h0, 16'h3000, 16'h0000, 5'b11100};
        tbl[1] = '{0, 1, 0, 0, 16'hBEEF, 16'h0, 16'h3000, 16'hBEEF, 5'b11100};
        tbl[2] = '{1, 0, 0, 0, 16'h0042, 16'h0, 16'h0042, 16'hBEEF, 5'b11100};
        tbl[3] = '{0, 0, 1, 0, 16'h0, 16'h1234, 16'h0042, 16'hBEEF, 5'b00101};
        tbl[4] = '{1, 1, 0, 0, 16'hFFFF, 16'h1234, 16'h0042, 16'hBEEF, 5'b00101};
        tbl[5] = '{0, 0, 0, 0, 16'h0, 16'h1234, 16'h0042, 16'hBEEF, 5'b00101};
        tbl[6] = '{0, 0, 0, 0, 16'h0, 16'h1234, 16'h0042, 16'h1234, 5'b11111};
        tbl[7] = '{0, 0, 0, 0, 16'h0, 16'h1234, 16'h0042, 16'h1234, 5'b11100};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].ld_mar, tbl[i].ld_mdr, tbl[i].rd, tbl[i].wr,
                  tbl[i].bus, tbl[i].rdata);
            expq.push_back(mk(tbl[i].mar, tbl[i].mdr, tbl[i].st));
            step();
            check($sformatf("vec%0d", i), obs_a(), expq.pop_front());
        end
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        wait_idle("idle_after_read");

        // WAIT_STATES=0 write.
        drive(1, 1, 0, 0, 16'h00A0, 16'h0);
        step();
        drive(0, 1, 0, 0, 16'h5A5A, 16'h0);
        step();
        drive(0, 0, 0, 1, 16'h0, 16'hEEEE);
        step();
        check("wr0_strobe", obs_b(), mk(16'h00A0, 16'h5A5A, 5'b01001));
        drive(0, 0, 0, 0, 16'hFFFF, 16'hEEEE);
        step();
        check("wr0_done", obs_b(), mk(16'h00A0, 16'h5A5A, 5'b11111));
        step();
        check("wr0_idle", obs_b(), mk(16'h00A0, 16'h5A5A, 5'b11100));
        wait_idle("idle_after_write");

        // Read and write together with LD_MAR: read wins at new address.
        drive(1, 0, 1, 1, 16'h0007, 16'hCAFE);
        step();
        drive(0, 0, 0, 0, 16'h0, 16'hCAFE);
        wlow = 0;
        rcnt = 0;
        badaddr = 0;
        for (int i = 0; i < 8; i++) begin
            if (!we_a) wlow++;
            if (r_a) rcnt++;
            if (!ce_a && addr_a != 16'h0007) badaddr++;
            step();
        end
        check("sim_we_never", 69'(wlow), 69'(0));
        check("sim_one_r", 69'(rcnt), 69'(1));
        check("sim_addr", 69'(badaddr), 69'(0));
        check("sim_mdr", 69'(mdr_a), 69'(16'hCAFE));

        // Reset in the middle of a read.
        drive(1, 0, 1, 0, 16'h0055, 16'h1111);
        step();
        drive(0, 0, 0, 0, 16'h0, 16'h1111);
        step();
        check("mid_rd_active", 69'({ce_a, oe_a}), 69'(0));
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset", obs_a(), mk(16'h0, 16'h0, 5'b11100));
        step();
        Reset_n = 1'b1;
        drive(1, 0, 1, 0, 16'h0066, 16'h2222);
        step();
        check("rst_new_rd", obs_a(), mk(16'h0066, 16'h0, 5'b00101));
        drive(0, 0, 0, 0, 16'h0, 16'h2222);
        n = 0;
        gotr = 1'b0;
        while (!gotr && n < 10) begin
            step();
            n++;
            gotr = r_a;
        end
        check("rst_rd_r_lat", 69'(n), 69'(3));
        check("rst_rd_mdr", obs_a(), mk(16'h0066, 16'h2222, 5'b11111));
        step();
        check("rst_rd_idle", 69'({busy_a, r_a}), 69'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
